// File: rtl/ucpu_serial_fetch.sv
// Serial fetch engine: shifts a fetch address out MSB-first on one pin, then shifts
// the returned word in MSB-first and offers it to decode. Optional UCPU_FETCH_PARITY_EN.
module ucpu_serial_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              addr_out,
    input  logic              data_in,
    output logic [1:0]        phase,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);
    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_RECV = 3'd2,
`ifdef UCPU_FETCH_PARITY_EN
        S_PAR  = 3'd4,
`endif
        S_RESP = 3'd3
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr_sr;
    logic [DATA_W-1:0]  data_sr;
    logic [DATA_W-1:0]  data_shift;
    logic               accept;
    logic               cnt_zero;

    assign accept     = (state == S_IDLE) && req_valid && !flush;
    assign cnt_zero   = (cnt == '0);
    assign data_shift = {data_sr[DATA_W-2:0], data_in};
    assign req_ready  = (state == S_IDLE);
    assign rsp_valid  = (state == S_RESP);

    always_comb begin
        state_n = state;
        phase   = 2'd0;
        case (state)
            S_IDLE: begin
                phase = 2'd0;
                if (accept) state_n = S_SEND;
            end
            S_SEND: begin
                phase = 2'd1;
                if (flush)         state_n = S_IDLE;
                else if (cnt_zero) state_n = S_RECV;
            end
            S_RECV: begin
                phase = 2'd2;
                if (flush)         state_n = S_IDLE;
`ifdef UCPU_FETCH_PARITY_EN
                else if (cnt_zero) state_n = S_PAR;
`else
                else if (cnt_zero) state_n = S_RESP;
`endif
            end
`ifdef UCPU_FETCH_PARITY_EN
            S_PAR: begin
                phase   = 2'd2;
                state_n = flush ? S_IDLE : S_RESP;
            end
`endif
            S_RESP: begin
                phase = 2'd3;
                // flush and rsp_ready both retire the word
                if (flush || rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr_sr  <= '0;
            data_sr  <= '0;
            addr_out <= 1'b0;
            rsp_data <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // first address bit is already on the pin in the first SEND cycle
                        addr_out <= req_addr[ADDR_W-1];
                        addr_sr  <= req_addr << 1;
                        cnt      <= CNT_W'(ADDR_W - 1);
                    end
                end
                S_SEND: begin
                    if (flush || cnt_zero) begin
                        addr_out <= 1'b0;
                        cnt      <= CNT_W'(DATA_W - 1);
                    end else begin
                        addr_out <= addr_sr[ADDR_W-1];
                        addr_sr  <= addr_sr << 1;
                        cnt      <= cnt - 1'b1;
                    end
                end
                S_RECV: begin
                    if (flush) begin
                        data_sr <= '0;
                    end else begin
                        data_sr <= data_shift;
                        if (cnt_zero) rsp_data <= data_shift;
                        else          cnt      <= cnt - 1'b1;
                    end
                end
                default: addr_out <= 1'b0;
            endcase
        end
    end

`ifdef UCPU_FETCH_PARITY_EN
    logic err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state == S_PAR && !flush) begin
            // even parity: word bits plus parity bit must XOR to zero
            err_q <= (^rsp_data) ^ data_in;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ucpu_serial_fetch.sv
// Bench for ucpu_serial_fetch: instruction (8/32) and micro (9/44) instances driven
// with random fetches and checked against a bit-stream/latency reference model.
module tb_ucpu_serial_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        flush     [2];
    logic        addr_out  [2];
    logic        data_in   [2];
    logic [1:0]  phase     [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic        rsp_err   [2];
    logic [7:0]  req_addr0;
    logic [8:0]  req_addr1;
    logic [31:0] rsp_data0;
    logic [43:0] rsp_data1;
    logic [63:0] last_word [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ucpu_serial_fetch #(.ADDR_W(8), .DATA_W(32)) u_inst (
        .clock(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr0), .flush(flush[0]), .addr_out(addr_out[0]), .data_in(data_in[0]),
        .phase(phase[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data0), .rsp_err(rsp_err[0])
    );

    ucpu_serial_fetch #(.ADDR_W(9), .DATA_W(44)) u_micro (
        .clock(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr1), .flush(flush[1]), .addr_out(addr_out[1]), .data_in(data_in[1]),
        .phase(phase[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data1), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rdata(input int sel);
        return (sel != 0) ? 64'(rsp_data1) : 64'(rsp_data0);
    endfunction

    function automatic logic [63:0] rand64(input int w);
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic set_addr(input int sel, input logic [63:0] a);
        if (sel != 0) req_addr1 = a[8:0];
        else          req_addr0 = a[7:0];
    endtask

    // One complete fetch on instance sel; flush_at >= 0 aborts at that RECV cycle.
    task automatic fetch(input int sel, input logic [63:0] addr, input logic [63:0] word,
                         input logic pbit, input int bp, input int flush_at);
        int aw, dw, lat, n, rx;
        logic bits[$];
        logic exp_err;
        aw = (sel != 0) ? 9 : 8;
        dw = (sel != 0) ? 44 : 32;
        for (int i = dw - 1; i >= 0; i--) bits.push_back(word[i]);
`ifdef UCPU_FETCH_PARITY_EN
        bits.push_back(pbit);
        lat     = aw + dw + 1;
        exp_err = (^word) ^ pbit;
`else
        lat     = aw + dw;
        exp_err = 1'b0;
`endif
        chk("idle_ready", 64'(req_ready[sel]), 64'd1);
        chk("idle_phase", 64'(phase[sel]), 64'd0);
        req_valid[sel] = 1'b1;
        set_addr(sel, addr);
        @(negedge clk);
        req_valid[sel] = 1'b0;
        set_addr(sel, rand64(aw));
        n  = 1;
        rx = 0;
        while (!rsp_valid[sel] && n <= lat + 5) begin
            if (n <= aw) begin
                chk("addr_bit", 64'(addr_out[sel]), 64'(addr[aw-n]));
                chk("send_phase", 64'(phase[sel]), 64'd1);
            end else begin
                chk("addr_idle", 64'(addr_out[sel]), 64'd0);
            end
            if (phase[sel] == 2'd2 && rx < bits.size()) begin
                data_in[sel] = bits[rx];
                if (rx == flush_at) flush[sel] = 1'b1;
                rx++;
            end else begin
                data_in[sel] = 1'($urandom);
            end
            @(negedge clk);
            if (flush[sel]) begin
                flush[sel] = 1'b0;
                chk("flush_phase", 64'(phase[sel]), 64'd0);
                chk("flush_addr", 64'(addr_out[sel]), 64'd0);
                chk("flush_keep", rdata(sel), last_word[sel]);
                repeat (3) begin
                    chk("flush_novalid", 64'(rsp_valid[sel]), 64'd0);
                    @(negedge clk);
                end
                return;
            end
            n++;
        end
        chk("latency", 64'(n - 1), 64'(lat));
        chk("resp_phase", 64'(phase[sel]), 64'd3);
        chk("resp_data", rdata(sel), word);
        chk("resp_err", 64'(rsp_err[sel]), 64'(exp_err));
        rsp_ready[sel] = 1'b0;
        repeat (bp) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid[sel]), 64'd1);
            chk("bp_data", rdata(sel), word);
        end
        rsp_ready[sel] = 1'b1;
        @(negedge clk);
        rsp_ready[sel] = 1'b0;
        chk("done_phase", 64'(phase[sel]), 64'd0);
        chk("done_valid", 64'(rsp_valid[sel]), 64'd0);
        chk("done_keep", rdata(sel), word);
        last_word[sel] = word;
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b1; flush[s] = 1'b0; data_in[s] = 1'b0;
            rsp_ready[s] = 1'b0; last_word[s] = '0;
        end
        req_addr0 = 8'hFF;
        req_addr1 = 9'h1FF;

        repeat (2) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                chk("rst_ready", 64'(req_ready[s]), 64'd1);
                chk("rst_phase", 64'(phase[s]), 64'd0);
                chk("rst_addr", 64'(addr_out[s]), 64'd0);
                chk("rst_valid", 64'(rsp_valid[s]), 64'd0);
                chk("rst_data", rdata(s), 64'd0);
                chk("rst_err", 64'(rsp_err[s]), 64'd0);
            end
        end
        reset = 1'b0;
        req_valid[1] = 1'b0;

        fetch(0, 64'hA5, 64'hDEADBEEF, 1'b0, 5, -1);
        fetch(1, 64'h0C3, 64'h0F0F1234ABC, 1'b1, 0, -1);
        fetch(0, rand64(8), rand64(32), 1'b0, 1, 9);
        fetch(0, rand64(8), rand64(32), 1'b1, 2, -1);

        // flush beats a simultaneous request in IDLE
        flush[0] = 1'b1; req_valid[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0; req_valid[0] = 1'b0;
        chk("flush_idle_phase", 64'(phase[0]), 64'd0);
        chk("flush_idle_ready", 64'(req_ready[0]), 64'd1);

`ifdef UCPU_FETCH_PARITY_EN
        fetch(0, 64'h3C, 64'h1, 1'b1, 0, -1);
        fetch(0, 64'h3C, 64'h1, 1'b0, 0, -1);
`endif

        for (int it = 0; it < 8; it++) begin
            for (int s = 0; s < 2; s++) begin
                int fa;
                fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (s != 0) ? 43 : 31) : -1;
                fetch(s, rand64((s != 0) ? 9 : 8), rand64((s != 0) ? 44 : 32),
                      1'($urandom), $urandom_range(0, 3), fa);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ucpu_serial_fetch.md
Name: ucpu_serial_fetch

Overview:
- CPU-side serial fetch engine for the pin-limited micro-coded CPU.
- Takes a parallel fetch request (PC or micro-PC) and shifts the address out MSB-first on a 1-bit pin.
- Then shifts in the returned instruction or micro-instruction word MSB-first on a 1-bit pin.
- Presents the assembled word to the decode stage with a valid/ready handshake.
- Instantiated twice: instruction path (8-bit address, 32-bit word) and micro-instruction path (9-bit address, 44-bit word).

Parameters:
ADDR_W, 8, width of fetch address shifted out (9 for micro path)
DATA_W, 32, width of word shifted in (44 for micro path)

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  fetch request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_addr  in  ADDR_W  fetch address, captured on accept
flush  in  1  synchronous abort; returns to IDLE
addr_out  out  1  serial address bit to off-chip memory
data_in  in  1  serial data bit from off-chip memory
phase  out  2  0=IDLE, 1=SEND_ADDR, 2=RECV_DATA, 3=RESP; mirrors the CPU state pins
rsp_valid  out  1  assembled word available
rsp_ready  in  1  decode stage consumes word
rsp_data  out  DATA_W  assembled word
rsp_err  out  1  parity error flag (see Optional Feature)

Behaviour:
- Reset values:
  - state IDLE; phase=0; req_ready=1.
  - addr_out=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - Internal counter and shift registers cleared.
  - Reset overrides flush and all handshakes.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: capture req_addr, load counter=ADDR_W-1, go to SEND_ADDR.
- SEND_ADDR: lasts exactly ADDR_W cycles.
  - addr_out is registered: cycle k (k=0..ADDR_W-1) drives req_addr[ADDR_W-1-k].
  - The first bit is valid in the first SEND_ADDR cycle.
  - After the last bit: counter=DATA_W-1, go to RECV_DATA.
- RECV_DATA: lasts exactly DATA_W cycles.
  - Each rising edge samples data_in into the LSB, shifting left, so the first bit received ends up in rsp_data[DATA_W-1].
  - After the DATA_W-th sample, go to RESP.
  - With the Optional Feature, go to PARITY first.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err held stable.
  - On rsp_ready at an edge: rsp_valid drops, go to IDLE.
  - req_ready returns to 1 in the following cycle; no same-cycle re-accept.
- addr_out=0 in every state except SEND_ADDR.
- rsp_data keeps the last word after the handshake. It is overwritten only by a new RECV_DATA.
- Latency: if accepted at edge T, rsp_valid is first high in the cycle after edge T+ADDR_W+DATA_W. Defaults: 40 cycles after accept (plus 1 with the parity feature).
- Counter wrap: the counter decrements to 0 and reloads on the state change. It never underflows; unused counter width is don't-care.
- flush:
  - Any non-IDLE state goes to IDLE at the next edge.
  - rsp_valid=0 and addr_out=0 next cycle; partial shift contents discarded; rsp_data not updated.
  - flush in IDLE with req_valid: flush wins, request not accepted.
- Simultaneous rsp_ready and flush in RESP: result is IDLE either way; the word counts as consumed.
- data_in is ignored outside RECV_DATA and PARITY. req_addr is ignored outside IDLE.

Optional Feature:
- Macro UCPU_FETCH_PARITY_EN.
- Defined:
  - One extra PARITY state after RECV_DATA; phase reads 2 during PARITY.
  - data_in is sampled as an even-parity bit over the word.
  - rsp_err = XOR of rsp_data bits XOR parity bit; it is valid in RESP.
  - rsp_err is cleared on accept of the next request.
- Undefined: no PARITY state; RECV_DATA goes directly to RESP; rsp_err tied 0.

Test Plan:
- Reset held 2 cycles with req_valid=1 -> req_ready=1, phase=0, addr_out=0, rsp_valid=0 throughout; release, then request accepted next edge.
- Defaults, req_addr=0xA5; bench returns 0xDEADBEEF MSB-first while phase=2 -> addr_out sequence 1,0,1,0,0,1,0,1 over 8 cycles; rsp_data=0xDEADBEEF; rsp_valid rises exactly 40 cycles after accept.
- ADDR_W=9, DATA_W=44, req_addr=0x0C3, word 0x0F0F_1234_ABC -> 9-bit stream 0,1,1,0,0,0,0,1,1; rsp_data equals the word.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable; rsp_ready=1 -> IDLE, and the next request is accepted one cycle later.
- flush asserted at the 10th RECV_DATA cycle -> phase=0 next cycle, rsp_valid never rises, rsp_data keeps its previous value; a new fetch afterwards completes correctly.
- With UCPU_FETCH_PARITY_EN: word 0x00000001 with parity bit 1 -> rsp_err=0; with parity bit 0 -> rsp_err=1; latency 41 cycles.
